script_sequencer: RTL and testbench

Parametrised successor to the single-step script analyser. It fetches 16-bit script words from the script memory by PC, decodes them and executes action, jump, wait and game-state instructions under a fetch/execute FSM. It supports free-run and single-step modes, conditional jumps, timed and condition waits with timeout, halt, and illegal-instruction trapping. It sits between the script memory and the traveler target/operate and game-state encoders.

---
 rtl/script_pkg.sv | 41 ++++
 rtl/ms_wait_counter.sv | 43 ++++
 rtl/script_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_script_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/script_pkg.sv
// Shared constants for the script sequencer: opcodes, funcs,
// FSM states and strobe/feedback bit positions.
package script_pkg;

  localparam logic [2:0] OP_SYS  = 3'b000;
  localparam logic [2:0] OP_ACT  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_WAIT = 3'b011;
  localparam logic [2:0] OP_GAME = 3'b100;

  localparam logic [1:0] F_NOP   = 2'b00;
  localparam logic [1:0] F_HALT  = 2'b11;
  localparam logic [1:0] F_TGT   = 2'b00;
  localparam logic [1:0] F_OPER  = 2'b01;
  localparam logic [1:0] F_JMP   = 2'b00;
  localparam logic [1:0] F_JNZ   = 2'b01;
  localparam logic [1:0] F_JZ    = 2'b10;
  localparam logic [1:0] F_WTIME = 2'b00;
  localparam logic [1:0] F_WHI   = 2'b01;
  localparam logic [1:0] F_WLO   = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH = 3'd0;
  localparam state_t S_EXEC  = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_GATE  = 3'd3;
  localparam state_t S_HALT  = 3'd4;

  localparam int OPS_MOVE     = 0;
  localparam int OPS_GET      = 1;
  localparam int OPS_PUT      = 2;
  localparam int OPS_INTERACT = 3;
  localparam int OPS_THROW    = 4;

  localparam int FB_FRONT   = 0;
  localparam int FB_HAND    = 1;
  localparam int FB_PROC    = 2;
  localparam int FB_MACHINE = 3;

endpackage

// File: rtl/ms_wait_counter.sv
// Millisecond tick counter shared by timed waits and
// condition-wait timeouts.
module ms_wait_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  input  logic             cond_mode,
  input  logic             en,
  input  logic             ms_tick,
  output logic             done,
  output logic             timeout
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic             mode;
  logic             reach;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt  <= '0;
      lim  <= '0;
      mode <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      lim  <= limit;
      mode <= cond_mode;
    end else if (en && ms_tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A zero limit never fires, which disables the timeout
  assign reach = en && ms_tick && (lim != '0)
              && ((cnt + CNT_W'(1)) == lim);

  assign done    = reach && !mode;
  assign timeout = reach && mode;

endmodule

// File: rtl/script_sequencer.sv
// Fetch/execute sequencer for 16-bit script words: actions,
// jumps, waits and game commands with halt/error trapping.
module script_sequencer #(
  parameter int PC_W       = 8,
  parameter int PC_STEP    = 2,
  parameter int TIMEOUT_MS = 10000,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            res,
  input  logic [15:0]     instr,
  input  logic            run_mode,
  input  logic            step,
  input  logic            ms_tick,
  input  logic [3:0]      feedback,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      target_id,
  output logic            target_stb,
  output logic [4:0]      op_stb,
  output logic [1:0]      game_cmd,
  output logic            game_stb,
  output logic            busy,
  output logic            halted,
  output logic            error
);

  import script_pkg::*;

  state_t state, state_n;

  logic [15:0]     ir;
  logic [7:0]      i_num;
  logic [1:0]      sel;
  logic [1:0]      func;
  logic [2:0]      op;
  logic            cond;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt;
  logic            misalign;

  assign i_num    = ir[15:8];
  assign sel      = ir[6:5];
  assign func     = ir[4:3];
  assign op       = ir[2:0];
  assign cond     = feedback[sel];
  assign pc_inc   = pc + PC_W'(PC_STEP);
  assign tgt      = PC_W'(i_num);
  assign misalign = (tgt % PC_W'(PC_STEP)) != '0;

  logic       illegal, do_halt, do_wait, take;
  logic       t_stb, g_stb;
  logic [4:0] o_stb;

  always_comb begin
    illegal = 1'b0;
    do_halt = 1'b0;
    do_wait = 1'b0;
    take    = 1'b0;
    t_stb   = 1'b0;
    g_stb   = 1'b0;
    o_stb   = '0;
    unique case (1'b1)
      (op == OP_SYS): begin
        do_halt = (func == F_HALT);
        illegal = (func != F_NOP) && (func != F_HALT);
      end
      (op == OP_ACT): begin
        if (func == F_TGT)
          t_stb = 1'b1;
        else if (func == F_OPER && i_num[2:0] <= 3'd4)
          o_stb = 5'b00001 << i_num[2:0];
        else
          illegal = 1'b1;
      end
      (op == OP_JMP): begin
        unique case (func)
          F_JMP:   take = 1'b1;
          F_JNZ:   take = cond;
          F_JZ:    take = !cond;
          default: illegal = 1'b1;
        endcase
        if (take && misalign)
          illegal = 1'b1;
      end
      (op == OP_WAIT): begin
        if (func == 2'b11)
          illegal = 1'b1;
        else
          do_wait = (func != F_WTIME) || (i_num != 8'd0);
      end
      (op == OP_GAME): g_stb = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  logic timed, cond_met, cnt_done, cnt_to;
  logic wait_ok, wait_to;

  assign timed    = (func == F_WTIME);
  assign cond_met = (func == F_WHI) ? cond : !cond;
  // The condition is checked first so it beats a same-cycle timeout
  assign wait_ok  = timed ? cnt_done : cond_met;
  assign wait_to  = !timed && cnt_to && !cond_met;

  ms_wait_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .res      (res),
    .load     (state == S_EXEC && do_wait),
    .limit    (timed ? CNT_W'(i_num) : CNT_W'(TIMEOUT_MS)),
    .cond_mode(!timed),
    .en       (state == S_WAIT),
    .ms_tick  (ms_tick),
    .done     (cnt_done),
    .timeout  (cnt_to)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        if (illegal || do_halt) state_n = S_HALT;
        else if (do_wait)       state_n = S_WAIT;
        else                    state_n = S_GATE;
      end
      S_WAIT: begin
        if (wait_ok)      state_n = S_GATE;
        else if (wait_to) state_n = S_HALT;
      end
      S_GATE: if (run_mode || step) state_n = S_FETCH;
      S_HALT: state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_FETCH;
      ir         <= '0;
      pc         <= '0;
      target_id  <= '0;
      target_stb <= 1'b0;
      op_stb     <= '0;
      game_cmd   <= '0;
      game_stb   <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != S_GATE) && (state_n != S_HALT);
      target_stb <= 1'b0;
      op_stb     <= '0;
      game_stb   <= 1'b0;
      if (state_n == S_HALT)
        halted <= 1'b1;
      if (state == S_FETCH)
        ir <= instr;
      if (state == S_EXEC) begin
        if (t_stb) begin
          target_id  <= i_num[4:0];
          target_stb <= 1'b1;
        end
        op_stb <= o_stb;
        if (g_stb) begin
          game_cmd <= func;
          game_stb <= 1'b1;
        end
        if (illegal)
          error <= 1'b1;
        else if (take)
          pc <= tgt;
        else if (!do_halt && !do_wait)
          pc <= pc_inc;
      end
      if (state == S_WAIT) begin
        if (wait_ok)
          pc <= pc_inc;
        else if (wait_to)
          error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_script_sequencer.sv
// Scenario bench for script_sequencer: strobe scoreboard plus
// per-task checks of pc, wait timing, step mode and reset.
module tb_script_sequencer;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] instr;
  logic        run_mode;
  logic        step;
  logic        ms_tick;
  logic [3:0]  feedback;
  logic [7:0]  pc;
  logic [4:0]  target_id;
  logic        target_stb;
  logic [4:0]  op_stb;
  logic [1:0]  game_cmd;
  logic        game_stb;
  logic        busy;
  logic        halted;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  typedef struct packed {
    logic       tstb;
    logic [4:0] tid;
    logic [4:0] ops;
    logic       gstb;
    logic [1:0] gcmd;
    logic [7:0] pc;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) instr <= mem[pc];

  script_sequencer #(
    .PC_W(8), .PC_STEP(2), .TIMEOUT_MS(4), .CNT_W(16)
  ) dut (
    .clk(clk), .res(res), .instr(instr),
    .run_mode(run_mode), .step(step), .ms_tick(ms_tick),
    .feedback(feedback), .pc(pc), .target_id(target_id),
    .target_stb(target_stb), .op_stb(op_stb),
    .game_cmd(game_cmd), .game_stb(game_stb),
    .busy(busy), .halted(halted), .error(error)
  );

  function automatic logic [15:0] enc(input logic [7:0] n,
    input logic [2:0] s, input logic [1:0] f, input logic [2:0] o);
    return {n, s, f, o};
  endfunction

  localparam logic [15:0] HALT_W = 16'h0018;

  always @(negedge clk) begin
    ev_t obs, e;
    if (res && (target_stb || op_stb != 5'd0 || game_stb)) begin
      obs = '{target_stb, target_stb ? target_id : 5'd0, op_stb,
              game_stb, game_stb ? game_cmd : 2'd0, pc};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got=%h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL strobe got=%h want=%h", obs, e);
        end
      end
    end
  end

  task automatic push_t(input logic [4:0] id, input logic [7:0] p);
    sb.push_back('{1'b1, id, 5'd0, 1'b0, 2'd0, p});
  endtask

  task automatic push_op(input int idx, input logic [7:0] p);
    sb.push_back('{1'b0, 5'd0, 5'(1 << idx), 1'b0, 2'd0, p});
  endtask

  task automatic push_g(input logic [1:0] c, input logic [7:0] p);
    sb.push_back('{1'b0, 5'd0, 5'd0, 1'b1, c, p});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    res = 1'b1;
  endtask

  task automatic check_sb(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL halt_timeout halted=%b want=1", halted);
    end
  endtask

  task automatic drive(input int from, input int to, input int phase,
    input int chg_at, input logic [3:0] fb_new);
    for (int n = from; n <= to; n++) begin
      @(negedge clk);
      ms_tick = (n % 10 == phase);
      if (n == chg_at) feedback = fb_new;
    end
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pc, target_id, game_cmd, target_stb, op_stb, game_stb,
         busy, halted, error} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs pc=%h tid=%h busy=%b", pc,
               target_id, busy);
    end
    res = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_release got=%b want=0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_first_edge got=%b want=1", busy);
    end
    wait_halt(20);
  endtask

  task automatic test_basic();
    int gap;
    clear_mem();
    mem[0] = enc(8'd5, 3'd0, 2'b00, 3'b001);
    mem[2] = enc(8'd1, 3'd0, 2'b01, 3'b001);
    push_t(5'd5, 8'd2);
    push_op(1, 8'd4);
    run_mode = 1'b1;
    do_reset();
    gap = 0;
    while (!target_stb && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (op_stb == 5'd0 && gap < 20);
    checks++;
    if (gap != 3) begin
      errors++;
      $display("FAIL throughput got=%0d want=3", gap);
    end
    wait_halt(30);
    checks++;
    if (pc !== 8'd4 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_halt pc=%h err=%b want pc=04 err=0",
               pc, error);
    end
    check_sb("basic_sb");
  endtask

  task automatic jump_case(input logic [3:0] fb, input logic [1:0] f,
    input logic [7:0] t, input logic [7:0] exp_pc,
    input logic exp_err);
    clear_mem();
    mem[0] = enc(t, 3'd0, f, 3'b010);
    feedback = fb;
    do_reset();
    wait_halt(40);
    checks++;
    if (pc !== exp_pc || error !== exp_err) begin
      errors++;
      $display("FAIL jump t=%h fb=%b pc=%h err=%b want pc=%h err=%b",
               t, fb, pc, error, exp_pc, exp_err);
    end
  endtask

  task automatic test_cond_jump();
    run_mode = 1'b1;
    jump_case(4'b0001, 2'b01, 8'h10, 8'h10, 1'b0);
    jump_case(4'b0000, 2'b01, 8'h10, 8'h02, 1'b0);
    jump_case(4'b0000, 2'b10, 8'h10, 8'h10, 1'b0);
    jump_case(4'b0000, 2'b00, 8'h11, 8'h00, 1'b1);
    check_sb("jump_sb");
    feedback = 4'd0;
  endtask

  task automatic timed_case(input int phase);
    int seen = 0;
    int done_at = 0;
    for (int p = 1; p < 100 && done_at == 0; p++)
      if (p % 10 == phase && p + 1 >= 3) begin
        seen++;
        if (seen == 3) done_at = p + 1;
      end
    clear_mem();
    mem[0] = enc(8'd3, 3'd0, 2'b00, 3'b011);
    ms_tick = 1'b0;
    do_reset();
    drive(1, done_at - 1, phase, -1, 4'd0);
    checks++;
    if (pc !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timed_early ph=%0d pc=%h busy=%b want 00/1",
               phase, pc, busy);
    end
    drive(done_at, done_at, phase, -1, 4'd0);
    checks++;
    if (pc !== 8'd2) begin
      errors++;
      $display("FAIL timed_done ph=%0d pc=%h want=02", phase, pc);
    end
    ms_tick = 1'b0;
  endtask

  task automatic test_timed_wait();
    run_mode = 1'b1;
    timed_case(5);
    timed_case(1);
    clear_mem();
    mem[0] = enc(8'd0, 3'd0, 2'b00, 3'b011);
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_zero pc=%h busy=%b want 02/0", pc, busy);
    end
  endtask

  task automatic test_cond_wait();
    run_mode = 1'b1;
    clear_mem();
    mem[0] = enc(8'd0, 3'b001, 2'b01, 3'b011);
    feedback = 4'd0;
    do_reset();
    drive(1, 35, 5, -1, 4'd0);
    checks++;
    if (error !== 1'b0 || pc !== 8'd0) begin
      errors++;
      $display("FAIL cond_pre err=%b pc=%h want 0/00", error, pc);
    end
    drive(36, 36, 5, -1, 4'd0);
    checks++;
    if (error !== 1'b1 || halted !== 1'b1 || pc !== 8'd0) begin
      errors++;
      $display("FAIL cond_timeout err=%b hlt=%b pc=%h want 1/1/00",
               error, halted, pc);
    end
    feedback = 4'd0;
    do_reset();
    drive(1, 35, 5, 35, 4'b0010);
    drive(36, 36, 5, -1, 4'd0);
    checks++;
    if (error !== 1'b0 || pc !== 8'd2) begin
      errors++;
      $display("FAIL cond_wins err=%b pc=%h want 0/02", error, pc);
    end
    ms_tick = 1'b0;
    mem[0] = enc(8'd0, 3'b001, 2'b10, 3'b011);
    feedback = 4'b0010;
    do_reset();
    drive(1, 10, -1, 10, 4'b0000);
    checks++;
    if (pc !== 8'd0) begin
      errors++;
      $display("FAIL cond_low_early pc=%h want=00", pc);
    end
    drive(11, 11, -1, -1, 4'd0);
    checks++;
    if (pc !== 8'd2 || error !== 1'b0) begin
      errors++;
      $display("FAIL cond_low pc=%h err=%b want 02/0", pc, error);
    end
    ms_tick = 1'b0;
  endtask

  task automatic step_once(input logic [7:0] exp_pc, input string nm);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (pc !== exp_pc || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pc=%h busy=%b want %h/0", nm, pc, busy, exp_pc);
    end
  endtask

  task automatic test_step();
    clear_mem();
    mem[0]    = enc(8'd7, 3'd0, 2'b00, 3'b001);
    mem[2]    = enc(8'd0, 3'd0, 2'b10, 3'b100);
    mem[4]    = enc(8'hFE, 3'd0, 2'b00, 3'b010);
    mem[8'hFE] = enc(8'd3, 3'd0, 2'b00, 3'b001);
    push_t(5'd7, 8'd2);
    push_g(2'b10, 8'd4);
    push_t(5'd3, 8'd0);
    push_t(5'd7, 8'd2);
    run_mode = 1'b0;
    step = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    checks++;
    if (pc !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL step_park pc=%h busy=%b want 02/0", pc, busy);
    end
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (pc !== 8'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL step_exec_ignored pc=%h busy=%b want 04/0",
               pc, busy);
    end
    step_once(8'hFE, "step_jump");
    step_once(8'h00, "step_wrap");
    step_once(8'h02, "step_after_wrap");
    check_sb("step_sb");
  endtask

  task automatic test_reset_mid_wait();
    clear_mem();
    mem[0] = enc(8'd9, 3'd0, 2'b00, 3'b001);
    mem[2] = enc(8'd0, 3'd0, 2'b11, 3'b100);
    mem[4] = enc(8'd5, 3'd0, 2'b00, 3'b011);
    push_t(5'd9, 8'd2);
    push_g(2'b11, 8'd4);
    run_mode = 1'b1;
    ms_tick = 1'b0;
    do_reset();
    repeat (15) @(negedge clk);
    checks++;
    if (pc !== 8'd4 || busy !== 1'b1 || target_id !== 5'd9 ||
        game_cmd !== 2'b11) begin
      errors++;
      $display("FAIL mid_wait pc=%h busy=%b tid=%h gc=%b",
               pc, busy, target_id, game_cmd);
    end
    #2 res = 1'b0;
    #1;
    checks++;
    if ({pc, target_id, game_cmd, target_stb, op_stb, game_stb,
         busy, halted, error} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset pc=%h tid=%h gc=%b busy=%b",
               pc, target_id, game_cmd, busy);
    end
    push_t(5'd9, 8'd2);
    push_g(2'b11, 8'd4);
    @(negedge clk);
    res = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 8'd2 || target_stb !== 1'b1) begin
      errors++;
      $display("FAIL restart pc=%h tstb=%b want 02/1", pc, target_stb);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (pc !== 8'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_wait pc=%h busy=%b want 04/1", pc, busy);
    end
    check_sb("reset_sb");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    res = 1'b0;
    run_mode = 1'b1;
    step = 1'b0;
    ms_tick = 1'b0;
    feedback = 4'd0;
    test_reset();
    test_basic();
    test_cond_jump();
    test_timed_wait();
    test_cond_wait();
    test_step();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
